// File: rtl/mod3_pkg.sv
// Shared types and helpers for the mod-3 checked serial frame.
package mod3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CHK_HI = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    typedef logic [1:0] residue_t;

    // MSB-first remainder update: r' = (2r + b) mod 3; value 3 never occurs.
    function automatic residue_t mod3_step(residue_t r, logic b);
        residue_t nxt;
        case (r)
            2'd0:    nxt = b ? 2'd1 : 2'd0;
            2'd1:    nxt = b ? 2'd0 : 2'd2;
            2'd2:    nxt = b ? 2'd2 : 2'd1;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Check field (3 - r) mod 3 that makes data*4 + check divisible by 3.
    function automatic logic [1:0] mod3_check(residue_t r);
        logic [1:0] c;
        case (r)
            2'd0:    c = 2'b00;
            2'd1:    c = 2'b10;
            2'd2:    c = 2'b01;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mod3_residue.sv
// Running mod-3 remainder of the payload bits already sent.
module mod3_residue
    import mod3_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     enable,
    input  logic     data_bit,
    output residue_t residue
);

    // Remainder register: cleared on reset or frame start, stepped per payload bit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            residue <= '0;
        end else if (enable) begin
            residue <= mod3_step(residue, data_bit);
        end
    end

endmodule

// File: rtl/mod3_frame_tx.sv
// Serial transmitter: payload MSB-first followed by a 2-bit mod-3 check field.
module mod3_frame_tx
    import mod3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              dout_first,
    output logic              dout_last
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state, state_n;
    logic [DATA_W-1:0] sr, sr_n, sr_shift;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              chk_lo, chk_lo_n;
    logic              dout_n, valid_n, first_n, last_n;
    logic              accept;
    logic [1:0]        chk;
    residue_t          residue;

    assign din_ready = (state == IDLE) || (state == CHK_LO);
    assign accept    = din_valid && din_ready;
    assign sr_shift  = sr << 1;

    // The residue register still lags the bit on dout, so the check field is
    // formed from one look-ahead step while the last payload bit is out.
    assign chk = mod3_check(mod3_step(residue, dout));

    mod3_residue u_residue (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (state == DATA),
        .data_bit (dout),
        .residue  (residue)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_n    = cnt;
        chk_lo_n = chk_lo;
        dout_n   = 1'b0;
        valid_n  = 1'b0;
        first_n  = 1'b0;
        last_n   = 1'b0;
        if (accept) begin
            state_n = DATA;
            sr_n    = din;
            cnt_n   = CNT_W'(DATA_W - 1);
            dout_n  = din[DATA_W-1];
            valid_n = 1'b1;
            first_n = 1'b1;
        end else begin
            case (state)
                DATA: begin
                    valid_n = 1'b1;
                    if (cnt == '0) begin
                        state_n  = CHK_HI;
                        dout_n   = chk[1];
                        chk_lo_n = chk[0];
                    end else begin
                        sr_n   = sr_shift;
                        cnt_n  = cnt - 1'b1;
                        dout_n = sr_shift[DATA_W-1];
                    end
                end
                CHK_HI: begin
                    state_n = CHK_LO;
                    valid_n = 1'b1;
                    dout_n  = chk_lo;
                    last_n  = 1'b1;
                end
                CHK_LO:  state_n = IDLE;
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr         <= '0;
            cnt        <= '0;
            chk_lo     <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            sr         <= sr_n;
            cnt        <= cnt_n;
            chk_lo     <= chk_lo_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            dout_first <= first_n;
            dout_last  <= last_n;
        end
    end

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Bench for mod3_frame_tx at DATA_W=8 and DATA_W=13 with scoreboard and detector model.
module tb_mod3_frame_tx;
    import mod3_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din8;
    logic [12:0] din13;
    logic        v8, v13;
    logic        ready8, dout8, dv8, df8, dl8;
    logic        ready13, dout13, dv13, df13, dl13;

    typedef struct packed { logic d; logic f; logic l; } bit_t;
    bit_t q8[$];
    bit_t q13[$];

    int n_assert = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;
    int r8 = 0, r13 = 0;
    int lasts8 = 0, lasts13 = 0;
    int run8 = 0, max8 = 0;

    always #5 clk = ~clk;

    mod3_frame_tx #(.DATA_W(8)) dut8 (
        .clk(clk), .reset(reset), .din(din8), .din_valid(v8), .din_ready(ready8),
        .dout(dout8), .dout_valid(dv8), .dout_first(df8), .dout_last(dl8)
    );

    mod3_frame_tx #(.DATA_W(13)) dut13 (
        .clk(clk), .reset(reset), .din(din13), .din_valid(v13), .din_ready(ready13),
        .dout(dout13), .dout_valid(dv13), .dout_first(df13), .dout_last(dl13)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: payload MSB-first, then check field, flags attached.
    task automatic push_frame(input bit w13, input logic [31:0] w);
        int         wd;
        logic [31:0] m;
        logic [1:0] c;
        bit_t       e;
        wd = w13 ? 13 : 8;
        m  = w & ((32'd1 << wd) - 32'd1);
        c  = mod3_check(residue_t'(m % 3));
        for (int i = wd - 1; i >= 0; i--) begin
            e = '{d: m[i], f: (i == wd - 1), l: 1'b0};
            if (w13) q13.push_back(e); else q8.push_back(e);
        end
        e = '{d: c[1], f: 1'b0, l: 1'b0};
        if (w13) q13.push_back(e); else q8.push_back(e);
        e = '{d: c[0], f: 1'b0, l: 1'b1};
        if (w13) q13.push_back(e); else q8.push_back(e);
    endtask

    // Called and returns at posedge+1; leaves din_valid high.
    task automatic send(input bit w13, input logic [31:0] w, output int waits);
        waits = 0;
        if (w13) begin din13 = w[12:0]; v13 = 1'b1; end
        else     begin din8  = w[7:0];  v8  = 1'b1; end
        @(negedge clk);
        while (!(w13 ? ready13 : ready8) && waits < 60) begin
            waits++;
            @(negedge clk);
        end
        if (!(w13 ? ready13 : ready8)) begin
            check("send_ready_timeout", w13 ? ready13 : ready8, 1);
            @(posedge clk); #1;
            return;
        end
        push_frame(w13, w);
        @(posedge clk); #1;
    endtask

    task automatic grab8(output logic [9:0] bits, output logic f0, output logic l9);
        int k;
        bits = '0; f0 = 1'b0; l9 = 1'b0; k = 0;
        @(negedge clk);
        while (!dv8 && k < 30) begin @(negedge clk); k++; end
        if (!dv8) begin
            check("grab_valid_timeout", dv8, 1);
            @(posedge clk); #1;
            return;
        end
        f0 = df8;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            bits = {bits[8:0], dout8};
            if (j == 9) l9 = dl8;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        v8 = 1'b0; v13 = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("gap_valid", dv8, 0);
            check("gap_dout", dout8, 0);
            check("gap_ready", ready8, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        v8 = 1'b0; v13 = 1'b0;
        while ((q8.size() != 0 || q13.size() != 0 || dv8 || dv13) && k < 100) begin
            @(negedge clk); k++;
        end
        if (q8.size() != 0 || q13.size() != 0)
            check("drain_timeout", q8.size() + q13.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic directed8(input string tag, input logic [7:0] w, input logic [9:0] exp);
        int         wt;
        logic [9:0] bits;
        logic       f0, l9;
        send(1'b0, {24'd0, w}, wt);
        v8 = 1'b0;
        grab8(bits, f0, l9);
        check({tag, "_bits"}, bits, exp);
        check({tag, "_first"}, f0, 1);
        check({tag, "_last"}, l9, 1);
    endtask

    // Scoreboard pop plus independent divisibility detector, DATA_W=8.
    always @(negedge clk) begin
        bit_t e;
        if (mon_on) begin
            if (dv8) begin
                if (q8.size() == 0) begin
                    check("sb8_unexpected_valid", dv8, 0);
                end else begin
                    e = q8.pop_front();
                    check("sb8_bit", {dout8, df8, dl8}, e);
                end
                r8 = df8 ? 0 : r8;
                r8 = (2 * r8 + int'(dout8)) % 3;
                if (dl8) begin
                    lasts8++;
                    check("det8_divisible", r8, 0);
                end
                run8++;
                if (run8 > max8) max8 = run8;
            end else begin
                run8 = 0;
                check("idle8_dout", dout8, 0);
            end
        end
    end

    // Scoreboard pop plus independent divisibility detector, DATA_W=13.
    always @(negedge clk) begin
        bit_t e;
        if (mon_on) begin
            if (dv13) begin
                if (q13.size() == 0) begin
                    check("sb13_unexpected_valid", dv13, 0);
                end else begin
                    e = q13.pop_front();
                    check("sb13_bit", {dout13, df13, dl13}, e);
                end
                r13 = df13 ? 0 : r13;
                r13 = (2 * r13 + int'(dout13)) % 3;
                if (dl13) begin
                    lasts13++;
                    check("det13_divisible", r13, 0);
                end
            end else begin
                check("idle13_dout", dout13, 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        logic [31:0] w;
        reset = 1'b1; v8 = 1'b0; v13 = 1'b0; din8 = '0; din13 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_dout", dout8, 0);
        check("rst_valid", dv8, 0);
        check("rst_first", df8, 0);
        check("rst_last", dl8, 0);
        check("rst_ready", ready8, 1);
        check("rst_valid13", dv13, 0);
        mon_on = 1'b1;
        @(posedge clk); #1;

        directed8("f05", 8'h05, 10'b0000010101);
        directed8("f07", 8'h07, 10'b0000011110);
        directed8("f00", 8'h00, 10'b0000000000);
        directed8("fff", 8'hFF, 10'b1111111100);

        // Back-to-back frames with din_valid held high.
        max8 = 0;
        send(1'b0, 32'h01, wt);
        check("b2b_wait_idle", wt, 0);
        send(1'b0, 32'h02, wt);
        check("b2b_wait_chklo", wt, 9);
        wait_drain();
        check("b2b_run", max8, 20);

        // Reset after three payload bits of A5.
        send(1'b0, 32'hA5, wt);
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        q8.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", dv8, 0);
        check("rst_mid_dout", dout8, 0);
        check("rst_mid_ready", ready8, 1);
        @(posedge clk); #1;
        directed8("f03", 8'h03, 10'b0000001100);

        idle(5);

        // Random loopback against the detector model.
        lasts8 = 0;
        for (int i = 0; i < 1000; i++) begin
            w = $urandom;
            send(1'b0, w, wt);
            if ($urandom_range(0, 7) == 0) begin
                v8 = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        check("lb8_frames", lasts8, 1000);

        lasts13 = 0;
        for (int i = 0; i < 1000; i++) begin
            w = $urandom;
            send(1'b1, w, wt);
            if ($urandom_range(0, 7) == 0) begin
                v13 = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        check("lb13_frames", lasts13, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mod3_frame_tx.md
Name: mod3_frame_tx

Overview:
- Serial transmitter for the mod-3 checked bitstream consumed by the team's MSB-first divisible-by-3 detector.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per cycle.
- Appends a 2-bit check field that makes the full frame value (data*4 + check) divisible by 3.
- A downstream detector restarted at frame start therefore reports "divisible" on the last bit of every good frame.

Parameters:
DATA_W, 8, payload width in bits (legal range 1..32).

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
din  input  DATA_W  parallel payload word.
din_valid  input  1  payload present.
din_ready  output  1  block can accept din this cycle.
dout  output  1  serial bit, MSB first.
dout_valid  output  1  dout carries a frame bit.
dout_first  output  1  first bit of frame (payload MSB); marks detector restart point.
dout_last  output  1  last bit of frame (check LSB).

Behaviour:
- One clock domain; synchronous, active-high reset; all outputs registered.
- Reset values: dout=0, dout_valid=0, dout_first=0, dout_last=0, state=IDLE, residue=0. din_ready is combinational from state and is 1 in IDLE after reset.
- Frame length is DATA_W+2 cycles: DATA_W payload bits, then check bits c[1], c[0]. There is no backpressure on the serial side; once started, a frame always runs to completion.
- States:
  - IDLE: waiting for a payload.
  - DATA: shifting payload; a bit counter runs DATA_W-1 down to 0.
  - CHK_HI: emitting c[1].
  - CHK_LO: emitting c[0].
- Transitions:
  - IDLE -> DATA on accept.
  - DATA -> CHK_HI after the bit with counter==0.
  - CHK_HI -> CHK_LO unconditionally.
  - CHK_LO -> DATA on accept (back-to-back frame), else CHK_LO -> IDLE.
- din_ready = (state==IDLE) || (state==CHK_LO). Accept = din_valid && din_ready; din is captured into the shift register on the accept edge.
- Latency: accept on edge N; payload MSB appears on dout with dout_valid=1 and dout_first=1 in the cycle after edge N.
- Back-to-back: an accept during CHK_LO makes the next frame's MSB immediately follow that frame's dout_last. There are zero idle cycles between frames.
- Residue: a 2-bit register is cleared on accept and updated per emitted payload bit b as r' = (2r + b) mod 3. Encodings: 0->0, 1->1, 2->2; value 3 is never reached.
- Check field = (3 - r) mod 3, using r after the last payload bit:
  - r=0 -> 2'b00
  - r=1 -> 2'b10
  - r=2 -> 2'b01
- dout_last=1 only in the CHK_LO cycle. Outside a frame, dout=0 and dout_valid=0.
- dout_first and dout_last are never both 1 (DATA_W >= 1).
- Reset mid-frame: the frame is abandoned immediately. Outputs return to reset values on the next edge, no remaining bits are emitted, and residue is cleared.
- din_valid with no accept has no effect; din is only sampled on accept.

Decomposition:
- Shared package mod3_pkg holds:
  - the state enum typedef (IDLE/DATA/CHK_HI/CHK_LO);
  - the residue typedef (2 bits);
  - constant function mod3_check(residue) -> 2-bit check. The same function is used by the bench scoreboard.
- One sub-module, mod3_residue, holds the residue register. It takes clear, enable and bit inputs and provides the residue output. It is the transmit-side mirror of the detector's state update.
- The rest (FSM, shift register, counter) stays in mod3_frame_tx.

Test Plan:
- DATA_W=8, din=8'h05 accepted from IDLE -> the 10 bits 0000_0101_01 follow on consecutive cycles, dout_first on bit 1, dout_last on bit 10. Frame value 21 ≡ 0 mod 3.
- din=8'h07 -> check 10, frame value 30. din=8'h00 -> check 00. din=8'hFF (255, r=0) -> check 00.
- din_valid held high with words 8'h01, 8'h02 -> 20 contiguous dout_valid cycles. din_ready pulses in IDLE then in each CHK_LO. Checks are 8'h01->10 and 8'h02->01.
- Reset asserted for 1 cycle after 3 payload bits of 8'hA5 -> dout_valid=0 from the following cycle. Next frame 8'h03 -> correct check 00, no stale residue.
- din_valid low for 5 cycles mid-stream -> dout_valid=0 and dout=0 during the gap. din_ready stays 1 in IDLE.
- Loopback with the divisibility detector, restarted on dout_first, 1000 random words at DATA_W=8 and DATA_W=13 -> the detector reports divisible on every dout_last cycle.
